serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 17 +
 rtl/fa_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 101 ++++++++++
 tb/tb_serial_add_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; kept at least one bit so degenerate widths still elaborate.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single full-adder cell, time-shared by the serial adder controller.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell processes WIDTH operand bits LSB first,
// with a start/busy/done handshake and a result held until the next completion.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             bit_s, bit_c;
  logic             last_bit;

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (bit_s),
    .cout (bit_c)
  );

  // The new sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign acc_next = {bit_s, acc[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_LAST);

  // NOTE: every output of a combinational block is assigned a default first so no
  // path through the case statement leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= bit_c;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= acc_next;
            cout <= bit_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pulses start for one cycle, then returns at the negedge where done is seen.
  // lat counts edges from the accepting edge; busy_n counts cycles with busy high.
  task automatic do_op(input int which, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, output int lat, output int busy_n);
    @(negedge clk);
    if (which == 2) begin a2 = av[1:0]; b2 = bv[1:0]; cin2 = ci; start2 = 1'b1; end
    else            begin a  = av;      b  = bv;      cin  = ci; start  = 1'b1; end
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    lat = 1; busy_n = 0;
    while (1) begin
      if ((which == 2) ? busy2 : busy) busy_n++;
      if (((which == 2) ? done2 : done) || lat >= 20) break;
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, bn, ndone, first_done, last_done;
  logic [8:0] exp9;

  initial begin
    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum",  sum,  0);
    check("rst_cout", cout, 0);
    @(negedge clk); rst = 1'b0;

    // 5A + 3C
    do_op(1, 8'h5A, 8'h3C, 1'b0, lat, bn);
    check("t1_lat",  lat, 9);
    check("t1_busy", bn,  9);
    check("t1_sum",  sum, 8'h96);
    check("t1_cout", cout, 0);
    @(negedge clk);
    check("t1_done_once", done, 0);
    check("t1_idle", busy, 0);

    // Carry-propagation boundaries
    do_op(1, 8'hFF, 8'h01, 1'b0, lat, bn);
    check("t2a_sum",  sum,  8'h00);
    check("t2a_cout", cout, 1);
    do_op(1, 8'hFF, 8'hFF, 1'b1, lat, bn);
    check("t2b_sum",  sum,  8'hFF);
    check("t2b_cout", cout, 1);
    @(negedge clk);

    // Start pulsed during RUN with new operands is ignored
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t3_hold_sum",  sum,  8'hFF);
    check("t3_hold_cout", cout, 1);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("t3_sum",  sum,  8'h02);
        check("t3_cout", cout, 0);
      end
    end
    check("t3_ndone", ndone, 1);

    // Asynchronous reset mid-operation
    a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_sum",  sum,  0);
    check("t4_cout", cout, 0);
    @(negedge clk); rst = 1'b0;
    do_op(1, 8'h10, 8'h20, 1'b0, lat, bn);
    check("t4_lat", lat, 9);
    check("t4_sum_after", sum, 8'h30);
    check("t4_cout_after", cout, 0);
    @(negedge clk);

    // Start held high: one result every WIDTH+2 cycles
    a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
    ndone = 0; first_done = -1; last_done = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = i;
        else check("t5_period", i - last_done, 10);
        last_done = i;
        ndone++;
        check("t5_sum",  sum,  8'h01);
        check("t5_cout", cout, 1);
      end
    end
    start = 1'b0;
    check("t5_first", first_done, 9);
    check("t5_ndone", ndone, 3);
    repeat (12) @(negedge clk);

    // Random operands against a + b + cin
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      do_op(1, ra, rb, rc, lat, bn);
      check("rnd_result", {cout, sum}, exp9);
    end

    // WIDTH=2 build, all operand combinations
    for (int i = 0; i < 32; i++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'(i & 3); rb = 8'((i >> 2) & 3); rc = 1'(i >> 4);
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      do_op(2, ra, rb, rc, lat, bn);
      check("w2_lat", lat, 3);
      check("w2_result", {cout2, sum2}, exp9[2:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
